// File: rtl/rf_scoreboard.sv
// Register file with integrated per-register pending-write scoreboard.
// Latency: reads, busy flags and iss_ok are combinational; writes and pend updates land on the next clk edge.
// Backpressure: iss_ok=0 when the destination's pending counter is saturated; decode must hold and retry.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset (clears regs and pend)
//   rs1_*/rs2_*         : two combinational read ports (address, data, pending-write busy flag)
//   iss_en/iss_rd/iss_ok: decode issue of an instruction writing iss_rd; iss_ok is the accept
//   wb_en/wb_addr/wb_data: writeback port, writes data and retires one pending write
//
// Optional feature: define RF_BYPASS_EN for write-first bypass from the writeback port to
// each read port. Register 0 reads as zero and never becomes busy. Addresses >= NREGS read
// as zero, are never busy, and are ignored for writes and issues (issues report iss_ok=1).
module rf_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int PCW   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ok,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data
);

    localparam logic [AW:0]    NREGS_W = NREGS[AW:0];
    localparam logic [PCW-1:0] PMAX    = '1;
    localparam logic [PCW-1:0] PONE    = PCW'(1);

    logic [XLEN-1:0] regs [NREGS];
    logic [PCW-1:0]  pend [NREGS];

    // Nonzero and inside the implemented register range.
    function automatic logic addr_valid(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NREGS_W);
    endfunction

    // ------------------------------------------------------------------
    // Issue acceptance: a saturated counter can still accept when a
    // writeback to the same register retires one entry this cycle.
    // Invalid destinations (x0, out of range) are always accepted.
    // ------------------------------------------------------------------
    always_comb begin
        iss_ok = 1'b1;
        if (addr_valid(iss_rd)) begin
            iss_ok = (pend[iss_rd] != PMAX) || (wb_en && (wb_addr == iss_rd));
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if (addr_valid(rs1_addr)) begin
            rs1_data = regs[rs1_addr];
            rs1_busy = (pend[rs1_addr] != '0);
`ifdef RF_BYPASS_EN
            // The forwarded write retires one pending entry, so the port
            // only stays busy if another write is still outstanding.
            if (wb_en && (wb_addr == rs1_addr)) begin
                rs1_data = wb_data;
                rs1_busy = (pend[rs1_addr] > PONE);
            end
`endif
        end
    end

    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if (addr_valid(rs2_addr)) begin
            rs2_data = regs[rs2_addr];
            rs2_busy = (pend[rs2_addr] != '0);
`ifdef RF_BYPASS_EN
            if (wb_en && (wb_addr == rs2_addr)) begin
                rs2_data = wb_data;
                rs2_busy = (pend[rs2_addr] > PONE);
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // State update. Entry 0 is never written, so it stays zero after reset.
    // ------------------------------------------------------------------
    logic wb_valid;
    logic iss_fire;

    always_comb begin
        wb_valid = wb_en && addr_valid(wb_addr);
        iss_fire = iss_en && addr_valid(iss_rd) && iss_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
                pend[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wb_valid && (wb_addr == i[AW-1:0])) begin
                    regs[i] <= wb_data;
                end
                // Issue and writeback to the same register cancel out.
                case ({iss_fire && (iss_rd == i[AW-1:0]),
                       wb_valid && (wb_addr == i[AW-1:0])})
                    2'b10:   pend[i] <= pend[i] + PONE;
                    2'b01:   if (pend[i] != '0) pend[i] <= pend[i] - PONE;
                    default: pend[i] <= pend[i];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
module tb_rf_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, iss_rd, wb_addr;
    logic [31:0] rs1_data, rs2_data, wb_data;
    logic        rs1_busy, rs2_busy, iss_en, iss_ok, wb_en;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_scoreboard dut (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .iss_ok   (iss_ok),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    // Advance past the next rising edge; inputs are then changed well away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; iss_en = 1'b0; wb_en = 1'b0;
        rs1_addr = '0; rs2_addr = '0; iss_rd = '0; wb_addr = '0; wb_data = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state over every address.
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            iss_rd   = 5'(a);
            #1;
            chk($sformatf("rst_rs1_data_%0d", a), rs1_data, 32'h0);
            chk($sformatf("rst_rs2_data_%0d", a), rs2_data, 32'h0);
            chk($sformatf("rst_busy_%0d", a), {30'd0, rs1_busy, rs2_busy}, 32'h0);
            chk($sformatf("rst_iss_ok_%0d", a), {31'd0, iss_ok}, 32'h1);
        end

        // Write x5, read on both ports next cycle.
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        wb_en = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        chk("x5_rs1", rs1_data, 32'hDEADBEEF);
        chk("x5_rs2", rs2_data, 32'hDEADBEEF);

        // Write to x0 is ignored.
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
        tick();
        wb_en = 1'b0; rs1_addr = 5'd0;
        #1;
        chk("x0_data", rs1_data, 32'h0);
        chk("x0_busy", {31'd0, rs1_busy}, 32'h0);

        // Issue to x0 never makes it busy.
        iss_en = 1'b1; iss_rd = 5'd0;
        tick();
        iss_en = 1'b0;
        #1;
        chk("x0_busy_after_issue", {31'd0, rs1_busy}, 32'h0);

        // Three issues to x7 fill the counter; a fourth is refused.
        iss_en = 1'b1; iss_rd = 5'd7; rs1_addr = 5'd7;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("x7_iss_ok_%0d", k), {31'd0, iss_ok}, 32'h1);
            chk($sformatf("x7_busy_pre_%0d", k), {31'd0, rs1_busy}, (k > 0) ? 32'h1 : 32'h0);
            tick();
        end
        #1;
        chk("x7_busy_full", {31'd0, rs1_busy}, 32'h1);
        chk("x7_iss_refused", {31'd0, iss_ok}, 32'h0);
        tick();
        iss_en = 1'b0;
        #1;
        chk("x7_still_full", {31'd0, iss_ok}, 32'h0);

        // Three writebacks drain x7; busy clears after the third.
        for (int k = 0; k < 3; k++) begin
            wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h70 + 32'(k);
            tick();
            wb_en = 1'b0;
            #1;
            chk($sformatf("x7_busy_drain_%0d", k), {31'd0, rs1_busy}, (k < 2) ? 32'h1 : 32'h0);
        end
        chk("x7_data", rs1_data, 32'h72);
        chk("x7_iss_ok_after_drain", {31'd0, iss_ok}, 32'h1);

        // x9 saturated, then simultaneous issue + writeback: accepted, count unchanged.
        iss_en = 1'b1; iss_rd = 5'd9;
        tick(); tick(); tick();
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hA5A5A5A5;
        #1;
        chk("x9_iss_ok_with_wb", {31'd0, iss_ok}, 32'h1);
        tick();
        iss_en = 1'b0; wb_en = 1'b0; rs1_addr = 5'd9;
        #1;
        chk("x9_data", rs1_data, 32'hA5A5A5A5);
        chk("x9_busy", {31'd0, rs1_busy}, 32'h1);
        chk("x9_pend_still_max", {31'd0, iss_ok}, 32'h0);

        // Writeback to idle x3 must not underflow its counter.
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
        tick();
        wb_en = 1'b0; rs1_addr = 5'd3; iss_rd = 5'd3;
        #1;
        chk("x3_busy_idle_wb", {31'd0, rs1_busy}, 32'h0);
        chk("x3_data_idle_wb", rs1_data, 32'h11);
        iss_en = 1'b1;
        tick();
        iss_en = 1'b0;
        #1;
        chk("x3_busy_one", {31'd0, rs1_busy}, 32'h1);
        chk("x3_iss_ok_one", {31'd0, iss_ok}, 32'h1);

        // Same-cycle read of x3 during its writeback; rs2 on x5 is unaffected.
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h55; rs2_addr = 5'd5;
        #1;
`ifdef RF_BYPASS_EN
        chk("x3_bypass_data", rs1_data, 32'h55);
        chk("x3_bypass_busy", {31'd0, rs1_busy}, 32'h0);
`else
        chk("x3_nobypass_data", rs1_data, 32'h11);
        chk("x3_nobypass_busy", {31'd0, rs1_busy}, 32'h1);
`endif
        chk("x5_other_port", rs2_data, 32'hDEADBEEF);
        tick();
        wb_en = 1'b0;
        #1;
        chk("x3_data_after", rs1_data, 32'h55);
        chk("x3_busy_after", {31'd0, rs1_busy}, 32'h0);

        // Issue and writeback to different registers both apply.
        iss_en = 1'b1; iss_rd = 5'd10;
        wb_en = 1'b1; wb_addr = 5'd11; wb_data = 32'hBB;
        tick();
        iss_en = 1'b0; wb_en = 1'b0; rs1_addr = 5'd10; rs2_addr = 5'd11;
        #1;
        chk("x10_busy", {31'd0, rs1_busy}, 32'h1);
        chk("x11_data", rs2_data, 32'hBB);
        chk("x11_busy", {31'd0, rs2_busy}, 32'h0);

        // Reset mid-operation beats writeback and issue.
        iss_en = 1'b1; iss_rd = 5'd4;
        tick(); tick();
        rst = 1'b1; wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
        tick();
        rst = 1'b0; wb_en = 1'b0; iss_en = 1'b0; rs1_addr = 5'd4; rs2_addr = 5'd9;
        #1;
        chk("x4_rst_data", rs1_data, 32'h0);
        chk("x4_rst_busy", {31'd0, rs1_busy}, 32'h0);
        chk("x4_rst_iss_ok", {31'd0, iss_ok}, 32'h1);
        chk("x9_rst_data", rs2_data, 32'h0);
        chk("x9_rst_busy", {31'd0, rs2_busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
